// File: rtl/reg_pipe_pkg.sv
// Shared definitions for the reg_pipe elastic register pipeline.
// Provides default geometry and the occupancy-counter width helper.
package reg_pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Bits needed to count 0..depth items inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One valid/data register pair of the reg_pipe chain.
// Data only loads when valid data arrives, so bubbles leave dat untouched.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] dat_in,
    output logic             vld_q,
    output logic [WIDTH-1:0] dat_q
);

    logic             vld_reg;
    logic [WIDTH-1:0] dat_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg <= 1'b0;
            dat_reg <= RESET_VAL;
        end else begin
            if (flush) begin
                vld_reg <= 1'b0;
            end else if (load) begin
                vld_reg <= vld_in;
            end
            // A flush discards in-flight items but leaves stored data as is.
            if (load && vld_in && !flush) begin
                dat_reg <= dat_in;
            end
        end
    end

    assign vld_q = vld_reg;
    assign dat_q = dat_reg;

endmodule

// File: rtl/reg_pipe.sv
// Elastic, bubble-collapsing valid/ready register pipeline of DEPTH stages.
// Optional occupancy output `occ` is enabled by defining REG_PIPE_OCC_EN.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occ
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("reg_pipe: DEPTH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("reg_pipe: WIDTH must be >= 1");
    end

    logic [DEPTH:0]   adv;
    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic             accept;

    // Ready ripples from the output back to the input: a stage can take new
    // data if it is empty or the stage after it is moving.
    always_comb begin
        adv        = '0;
        adv[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = !vld[i] || adv[i+1];
        end
    end

    assign in_ready = adv[0] && !flush && !rst;
    assign accept   = in_valid && in_ready;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             vld_in;
        logic [WIDTH-1:0] dat_in;

        if (gi == 0) begin : g_head
            assign vld_in = accept;
            assign dat_in = in_data;
        end else begin : g_body
            assign vld_in = vld[gi-1];
            assign dat_in = dat[gi-1];
        end

        reg_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush),
            .load   (adv[gi]),
            .vld_in (vld_in),
            .dat_in (dat_in),
            .vld_q  (vld[gi]),
            .dat_q  (dat[gi])
        );
    end

    assign out_valid = vld[DEPTH-1] && !flush;
    assign out_data  = dat[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
    localparam int OW = occ_width(DEPTH);

    logic [OW-1:0] occ_reg;
    logic          out_fire;

    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg <= '0;
        end else if (flush) begin
            occ_reg <= '0;
        end else if (accept && !out_fire) begin
            occ_reg <= occ_reg + OW'(1);
        end else if (!accept && out_fire) begin
            occ_reg <= occ_reg - OW'(1);
        end
    end

    assign occ = occ_reg;

`ifndef SYNTHESIS
    // The counter must always agree with the number of occupied stages.
    always @(posedge clk) begin
        if (!rst) begin
            assert (occ_reg == OW'($countones(vld)))
            else $error("reg_pipe: occ %0d disagrees with valid count %0d",
                        occ_reg, $countones(vld));
        end
    end
`endif
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Directed table-driven bench for reg_pipe at DEPTH 2 and 4, plus a
// randomised DEPTH=1 scoreboard run.
module tb_reg_pipe;
    import reg_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        fl2, iv2, ir2, ov2, or2;
    logic [31:0] id2, od2;
    logic        fl4, iv4, ir4, ov4, or4;
    logic [31:0] id4, od4;
    logic        fl1, iv1, ir1, ov1, or1;
    logic [31:0] id1, od1;
`ifdef REG_PIPE_OCC_EN
    logic [occ_width(2)-1:0] occ2;
    logic [occ_width(4)-1:0] occ4;
    logic [occ_width(1)-1:0] occ1;
`endif

    reg_pipe #(.WIDTH(32), .DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .flush(fl2), .in_valid(iv2), .in_ready(ir2),
        .in_data(id2), .out_valid(ov2), .out_ready(or2), .out_data(od2)
`ifdef REG_PIPE_OCC_EN
        , .occ(occ2)
`endif
    );

    reg_pipe #(.WIDTH(32), .DEPTH(4), .RESET_VAL(32'hDEAD_BEEF)) u4 (
        .clk(clk), .rst(rst), .flush(fl4), .in_valid(iv4), .in_ready(ir4),
        .in_data(id4), .out_valid(ov4), .out_ready(or4), .out_data(od4)
`ifdef REG_PIPE_OCC_EN
        , .occ(occ4)
`endif
    );

    reg_pipe #(.WIDTH(32), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
        .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1)
`ifdef REG_PIPE_OCC_EN
        , .occ(occ1)
`endif
    );

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        fl;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    vec_t t2 [18];
    vec_t t4 [14];

    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                                input logic fl, input logic ir, input logic ov,
                                input logic [31:0] od);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one vector on the selected pipe, then compare pre-edge outputs.
    task automatic apply(input int which, input int idx, input vec_t v);
        logic        ir, ov;
        logic [31:0] od;
        @(negedge clk);
        if (which == 2) begin
            iv2 = v.iv; id2 = v.id; or2 = v.ordy; fl2 = v.fl;
        end else begin
            iv4 = v.iv; id4 = v.id; or4 = v.ordy; fl4 = v.fl;
        end
        #1;
        ir = (which == 2) ? ir2 : ir4;
        ov = (which == 2) ? ov2 : ov4;
        od = (which == 2) ? od2 : od4;
        check($sformatf("d%0d[%0d].in_ready", which, idx), {31'b0, ir}, {31'b0, v.exp_ir});
        check($sformatf("d%0d[%0d].out_valid", which, idx), {31'b0, ov}, {31'b0, v.exp_ov});
        check($sformatf("d%0d[%0d].out_data", which, idx), od, v.exp_od);
        $display("d%0d vec %0d: iv=%0b id=%h ordy=%0b fl=%0b -> ir=%0b ov=%0b od=%h",
                 which, idx, v.iv, v.id, v.ordy, v.fl, ir, ov, od);
    endtask

    initial begin
        logic [31:0] q [$];
        logic        e_ir, e_ov;

        // Streaming, backpressure and flush on DEPTH=2.
        t2[0]  = mk(1, 32'h11, 1, 0, 1, 0, 32'h0);
        t2[1]  = mk(1, 32'h22, 1, 0, 1, 0, 32'h0);
        t2[2]  = mk(1, 32'h33, 1, 0, 1, 1, 32'h11);
        t2[3]  = mk(0, 32'h0,  1, 0, 1, 1, 32'h22);
        t2[4]  = mk(0, 32'h0,  1, 0, 1, 1, 32'h33);
        t2[5]  = mk(0, 32'h0,  1, 0, 1, 0, 32'h33);
        t2[6]  = mk(1, 32'hA,  0, 0, 1, 0, 32'h33);
        t2[7]  = mk(1, 32'hB,  0, 0, 1, 0, 32'h33);
        t2[8]  = mk(1, 32'hC,  0, 0, 0, 1, 32'hA);
        t2[9]  = mk(1, 32'hC,  1, 0, 1, 1, 32'hA);
        t2[10] = mk(0, 32'h0,  1, 0, 1, 1, 32'hB);
        t2[11] = mk(0, 32'h0,  1, 0, 1, 1, 32'hC);
        t2[12] = mk(0, 32'h0,  1, 0, 1, 0, 32'hC);
        t2[13] = mk(1, 32'h44, 0, 0, 1, 0, 32'hC);
        t2[14] = mk(1, 32'h55, 0, 0, 1, 0, 32'hC);
        t2[15] = mk(1, 32'hF,  1, 1, 0, 0, 32'h44);
        t2[16] = mk(0, 32'h0,  1, 0, 1, 0, 32'h44);
        t2[17] = mk(0, 32'h0,  1, 0, 1, 0, 32'h44);

        // Bubble collapse and full-stall on DEPTH=4.
        t4[0]  = mk(1, 32'h1, 0, 0, 1, 0, 32'hDEAD_BEEF);
        t4[1]  = mk(0, 32'h0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        t4[2]  = mk(1, 32'h2, 0, 0, 1, 0, 32'hDEAD_BEEF);
        t4[3]  = mk(0, 32'h0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        t4[4]  = mk(0, 32'h0, 0, 0, 1, 1, 32'h1);
        t4[5]  = mk(1, 32'h3, 0, 0, 1, 1, 32'h1);
        t4[6]  = mk(1, 32'h4, 0, 0, 1, 1, 32'h1);
        t4[7]  = mk(1, 32'h5, 0, 0, 0, 1, 32'h1);
        t4[8]  = mk(1, 32'h5, 0, 0, 0, 1, 32'h1);
        t4[9]  = mk(0, 32'h0, 1, 0, 1, 1, 32'h1);
        t4[10] = mk(0, 32'h0, 1, 0, 1, 1, 32'h2);
        t4[11] = mk(0, 32'h0, 1, 0, 1, 1, 32'h3);
        t4[12] = mk(0, 32'h0, 1, 0, 1, 1, 32'h4);
        t4[13] = mk(0, 32'h0, 1, 0, 1, 0, 32'h4);

        rst = 1'b1;
        fl2 = 0; iv2 = 0; id2 = '0; or2 = 0;
        fl4 = 0; iv4 = 0; id4 = '0; or4 = 0;
        fl1 = 0; iv1 = 0; id1 = '0; or1 = 0;

        // Reset is visible before any clock edge.
        #1;
        check("rst.out_valid", {31'b0, ov2}, 32'h0);
        check("rst.out_data", od2, 32'h0);
        check("rst.in_ready", {31'b0, ir2}, 32'h0);
        check("rst.out_data_d4", od4, 32'hDEAD_BEEF);
        check("rst.in_ready_d1", {31'b0, ir1}, 32'h0);
        $display("reset applied: ir=%0b ov=%0b od=%h", ir2, ov2, od2);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel.in_ready", {31'b0, ir2}, 32'h1);
        check("rel.in_ready_d4", {31'b0, ir4}, 32'h1);

        for (int i = 0; i < 18; i++) begin
            apply(2, i, t2[i]);
`ifdef REG_PIPE_OCC_EN
            if (i == 16) check("flush.occ", {30'b0, occ2}, 32'h0);
`endif
        end
        for (int i = 0; i < 14; i++) begin
            apply(4, i, t4[i]);
`ifdef REG_PIPE_OCC_EN
            if (i == 7) check("full.occ", {29'b0, occ4}, 32'h4);
`endif
        end

        // Reset mid-operation clears valid without a clock edge.
        apply(2, 100, mk(1, 32'h66, 0, 0, 1, 0, 32'h44));
        apply(2, 101, mk(1, 32'h77, 0, 0, 1, 0, 32'h44));
        apply(2, 102, mk(0, 32'h0,  0, 0, 0, 1, 32'h66));
        #2;
        rst = 1'b1;
        #1;
        check("midrst.out_valid", {31'b0, ov2}, 32'h0);
        check("midrst.out_data", od2, 32'h0);
        check("midrst.in_ready", {31'b0, ir2}, 32'h0);
        $display("mid-run reset: ov=%0b od=%h", ov2, od2);
        @(negedge clk);
        rst = 1'b0;

        // DEPTH=1 random traffic against a queue model.
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            iv1 = 1'($urandom);
            id1 = $urandom;
            or1 = 1'($urandom);
            fl1 = ($urandom_range(0, 31) == 0);
            #1;
            e_ir = !fl1 && (q.size() == 0 || or1);
            e_ov = !fl1 && (q.size() != 0);
            check($sformatf("d1[%0d].in_ready", c), {31'b0, ir1}, {31'b0, e_ir});
            check($sformatf("d1[%0d].out_valid", c), {31'b0, ov1}, {31'b0, e_ov});
`ifdef REG_PIPE_OCC_EN
            check($sformatf("d1[%0d].occ", c), {31'b0, occ1}, q.size());
`endif
            if (e_ov && or1) begin
                check($sformatf("d1[%0d].out_data", c), od1, q[0]);
                $display("d1 cycle %0d: out %h", c, od1);
                void'(q.pop_front());
            end
            if (fl1) begin
                q.delete();
            end else if (iv1 && e_ir) begin
                q.push_back(id1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
